intra_mode_sched: RTL and testbench
===================================

INTRA_MODE_SCHED -- requirements
Module: intra_mode_sched

Interface
REQ-001 Parameter NUM_MODES, default 35, number of intra modes swept (0 planar, 1 DC, 2..34 angular).
REQ-002 Parameter COST_W, default 16, width of the per-mode cost.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  pulse; begins a sweep of one 4x4 block.
REQ-007 abort  in  1  cancels the current sweep.
REQ-008 pred_req  out  1  request to the sample generator to produce the block for pred_mode.
REQ-009 pred_mode  out  6  mode number being requested.
REQ-010 pred_ack  in  1  generator accepted pred_req/pred_mode.
REQ-011 cost_valid  in  1  cost of the outstanding mode is present.
REQ-012 cost  in  COST_W  distortion of the outstanding mode, unsigned.
REQ-013 busy  out  1  sweep in progress.
REQ-014 done  out  1  one-cycle pulse; results valid.
REQ-015 best_mode  out  6  lowest-cost mode of the last completed sweep.
REQ-016 best_cost  out  COST_W  cost of best_mode.
REQ-017 eval_cnt  out  6  number of modes evaluated in the last completed sweep.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT, FIN; one mode outstanding at a time.
REQ-019 IDLE: busy=0; start=1 and abort=0 -> ISSUE, mode counter=0, running best cost=all ones, running best mode=0.
REQ-020 ISSUE: pred_req=1, pred_mode=mode counter; pred_ack=1 -> WAIT next cycle; pred_req SHALL stay high and pred_mode stable until pred_ack.
REQ-021 WAIT: pred_req=0; cost_valid=1 -> compare; cost strictly less than running best replaces best (ties keep the lower mode).
REQ-022 WAIT with cost_valid and mode counter=NUM_MODES-1 -> FIN; otherwise mode counter+1 -> ISSUE.
REQ-023 Minimum per-mode period SHALL be 2 cycles (ack in ISSUE cycle, cost_valid in first WAIT cycle).
REQ-024 FIN: best_mode, best_cost, eval_cnt loaded from running values; done=1 for exactly this cycle; -> IDLE.
REQ-025 cost_valid outside WAIT and pred_ack outside ISSUE SHALL be ignored.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 in ISSUE or WAIT -> IDLE next cycle, no done, result outputs unchanged; abort has priority over start and over cost_valid in the same cycle.
REQ-028 busy SHALL be 1 in ISSUE, WAIT and FIN.

Reset
REQ-029 rst SHALL force IDLE, pred_req=0, pred_mode=0, busy=0, done=0, best_mode=0, best_cost=all ones, eval_cnt=0, immediately and independent of clk.
REQ-030 Reset mid-sweep SHALL discard all running state; first cycle after release is IDLE.

Configuration
REQ-031 Macro INTRA_EARLY_TERM_EN: when defined, input early_thr [COST_W-1:0] exists; in WAIT, cost_valid with cost <= early_thr SHALL update best as normal and go to FIN regardless of mode counter.
REQ-032 Without INTRA_EARLY_TERM_EN the early_thr port SHALL be absent and every sweep SHALL evaluate all NUM_MODES modes.

Structure
REQ-033 Package intra_pkg SHALL hold NUM_MODES default, MODE_W=6, MODE_PLANAR=0, MODE_DC=1, and the scheduler state enum.
REQ-034 Sub-module intra_best_trk SHALL hold the running best cost/mode register and strict-less comparator; the FSM and counters stay in intra_mode_sched.

Verification
REQ-035 start, ack same cycle, cost=100-mode for all modes -> done after 70 cycles, best_mode=34, best_cost=66, eval_cnt=35.
REQ-036 All costs 50 -> best_mode=0 (tie keeps planar), best_cost=50.
REQ-037 pred_ack held off 3 cycles for mode 5 -> pred_req and pred_mode=5 stable for 4 cycles, final results unchanged versus zero-stall run.
REQ-038 abort asserted in WAIT of mode 10 -> IDLE next cycle, no done, best_mode/best_cost keep prior sweep values; new start then completes normally.
REQ-039 start during sweep and stray cost_valid in ISSUE -> both ignored, eval_cnt=35.
REQ-040 With INTRA_EARLY_TERM_EN, early_thr=20, cost of mode 1=15, others 200 -> done after mode 1, best_mode=1, best_cost=15, eval_cnt=2.

Source files
------------

// File: rtl/intra_pkg.sv
// Shared constants and the scheduler state type for the intra-mode sweep scheduler.
package intra_pkg;

  localparam int NUM_MODES_DEFAULT = 35;
  localparam int MODE_W            = 6;

  localparam logic [MODE_W-1:0] MODE_PLANAR = 6'd0;
  localparam logic [MODE_W-1:0] MODE_DC     = 6'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/intra_mode_sched_if.sv
// Request/cost handshake between the mode scheduler (master) and the sample generator (slave).
interface intra_mode_sched_if #(
  parameter int COST_W = 16
);
  import intra_pkg::*;

  logic                pred_req;
  logic [MODE_W-1:0]   pred_mode;
  logic                pred_ack;
  logic                cost_valid;
  logic [COST_W-1:0]   cost;

  modport master (
    output pred_req,
    output pred_mode,
    input  pred_ack,
    input  cost_valid,
    input  cost
  );

  modport slave (
    input  pred_req,
    input  pred_mode,
    output pred_ack,
    output cost_valid,
    output cost
  );

endinterface

// File: rtl/intra_best_trk.sv
// Running minimum tracker: holds the best cost/mode of the current sweep and exposes the
// value merged with the cost being sampled this cycle, so a final result can be loaded in one step.
module intra_best_trk
  import intra_pkg::*;
#(
  parameter int COST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample,
  input  logic [COST_W-1:0] cost,
  input  logic [MODE_W-1:0] mode,
  output logic [COST_W-1:0] merged_cost,
  output logic [MODE_W-1:0] merged_mode
);

  logic [COST_W-1:0] run_cost;
  logic [MODE_W-1:0] run_mode;
  logic              better;

  // Strict less-than: on a tie the earlier (lower) mode is kept.
  assign better      = sample && (cost < run_cost);
  assign merged_cost = better ? cost : run_cost;
  assign merged_mode = better ? mode : run_mode;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cost <= '1;
      run_mode <= MODE_PLANAR;
    end else if (clear) begin
      run_cost <= '1;
      run_mode <= MODE_PLANAR;
    end else begin
      run_cost <= merged_cost;
      run_mode <= merged_mode;
    end
  end

endmodule

// File: rtl/intra_mode_sched.sv
// Intra-mode sweep scheduler: requests each mode from the sample generator, one outstanding
// at a time, and reports the lowest-cost mode. Optional macro INTRA_EARLY_TERM_EN adds early_thr.
module intra_mode_sched
  import intra_pkg::*;
#(
  parameter int NUM_MODES = NUM_MODES_DEFAULT,
  parameter int COST_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  intra_mode_sched_if.master  gen,
`ifdef INTRA_EARLY_TERM_EN
  input  logic [COST_W-1:0]   early_thr,
`endif
  output logic                busy,
  output logic                done,
  output logic [MODE_W-1:0]   best_mode,
  output logic [COST_W-1:0]   best_cost,
  output logic [MODE_W-1:0]   eval_cnt
);

  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  sched_state_t      state;
  sched_state_t      next_state;
  logic [MODE_W-1:0] mode_cnt;
  logic              accept_start;
  logic              cost_take;
  logic              early_hit;
  logic              sweep_end;
  logic [COST_W-1:0] trk_cost;
  logic [MODE_W-1:0] trk_mode;

  // Abort outranks both start and a cost arriving in the same cycle.
  assign accept_start = (state == IDLE) && start && !abort;
  assign cost_take    = (state == WAIT) && gen.cost_valid && !abort;

`ifdef INTRA_EARLY_TERM_EN
  assign early_hit = cost_take && (gen.cost <= early_thr);
`else
  assign early_hit = 1'b0;
`endif

  assign sweep_end = cost_take && ((mode_cnt == LAST_MODE) || early_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: defaulting every combinational output first keeps each path assigned, so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept_start) next_state = ISSUE;
      ISSUE: begin
        if (abort)             next_state = IDLE;
        else if (gen.pred_ack) next_state = WAIT;
      end
      WAIT: begin
        if (abort)          next_state = IDLE;
        else if (sweep_end) next_state = FIN;
        else if (cost_take) next_state = ISSUE;
      end
      FIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    gen.pred_req  = 1'b0;
    gen.pred_mode = '0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      IDLE:  busy = 1'b0;
      ISSUE: begin
        gen.pred_req  = 1'b1;
        gen.pred_mode = mode_cnt;
      end
      WAIT:  ;
      FIN:   done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_cnt <= '0;
    end else if (accept_start) begin
      mode_cnt <= MODE_PLANAR;
    end else if (cost_take && !sweep_end) begin
      mode_cnt <= mode_cnt + 1'b1;
    end
  end

  intra_best_trk #(
    .COST_W (COST_W)
  ) u_best_trk (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept_start),
    .sample      (cost_take),
    .cost        (gen.cost),
    .mode        (mode_cnt),
    .merged_cost (trk_cost),
    .merged_mode (trk_mode)
  );

  // Results load on the edge into FIN so they are already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_mode <= MODE_PLANAR;
      best_cost <= '1;
      eval_cnt  <= '0;
    end else if (sweep_end) begin
      best_mode <= trk_mode;
      best_cost <= trk_cost;
      eval_cnt  <= mode_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_intra_mode_sched.sv
// Directed bench for intra_mode_sched: a small generator model answers requests from a cost table.
module tb_intra_mode_sched;
  import intra_pkg::*;

  localparam int NM = 35;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [5:0]  best_mode;
  logic [15:0] best_cost;
  logic [5:0]  eval_cnt;
`ifdef INTRA_EARLY_TERM_EN
  logic [15:0] early_thr;
`endif

  intra_mode_sched_if #(.COST_W(16)) sif ();

  intra_mode_sched #(.NUM_MODES(NM), .COST_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .gen       (sif),
`ifdef INTRA_EARLY_TERM_EN
    .early_thr (early_thr),
`endif
    .busy      (busy),
    .done      (done),
    .best_mode (best_mode),
    .best_cost (best_cost),
    .eval_cnt  (eval_cnt)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;
  int cost_tab [NM];
  int stall_mode   = -1;
  int stall_cycles = 0;
  int stall_obs    = 0;
  int abort_mode   = -1;
  int start_poke   = -1;
  bit stray_cv     = 1'b0;
  bit abort_fired  = 1'b0;
  int done_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Generator model: acks a request (after an optional stall), then returns the cost one cycle later.
  initial begin
    bit         ack_pend = 1'b0;
    bit         req_seen = 1'b0;
    int         stall_left = 0;
    logic [5:0] ack_mode = '0;
    sif.pred_ack   = 1'b0;
    sif.cost_valid = 1'b0;
    sif.cost       = '0;
    abort          = 1'b0;
    forever begin
      @(negedge clk);
      sif.pred_ack   = 1'b0;
      sif.cost_valid = 1'b0;
      sif.cost       = '0;
      abort          = 1'b0;
      if (rst) begin
        ack_pend = 1'b0;
        req_seen = 1'b0;
      end else if (ack_pend) begin
        ack_pend = 1'b0;
        req_seen = 1'b0;
        sif.cost_valid = 1'b1;
        if (int'(ack_mode) == abort_mode) begin
          abort       = 1'b1;
          abort_fired = 1'b1;
        end else begin
          sif.cost = 16'(cost_tab[ack_mode]);
        end
      end else if (sif.pred_req) begin
        if (!req_seen) begin
          req_seen   = 1'b1;
          stall_left = (int'(sif.pred_mode) == stall_mode) ? stall_cycles : 0;
        end
        if (int'(sif.pred_mode) == stall_mode) stall_obs++;
        if (stray_cv) sif.cost_valid = 1'b1;
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          sif.pred_ack = 1'b1;
          ack_pend     = 1'b1;
          ack_mode     = sif.pred_mode;
        end
      end
    end
  end

  task automatic run_sweep(input string tag, input int exp_cyc, input int exp_mode,
                           input int exp_cost, input int exp_eval);
    int cyc;
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (cyc == start_poke);
    end
    start = 1'b0;
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_busy_fin"}, 32'(busy), 1);
    check({tag, "_best_mode"}, 32'(best_mode), exp_mode);
    check({tag, "_best_cost"}, 32'(best_cost), exp_cost);
    check({tag, "_eval_cnt"}, 32'(eval_cnt), exp_eval);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 0);
    check({tag, "_busy_idle"}, 32'(busy), 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    rst   = 1'b1;
    start = 1'b0;
`ifdef INTRA_EARLY_TERM_EN
    early_thr = 16'd0;
`endif
    #12;
    check("rst_pred_req", 32'(sif.pred_req), 0);
    check("rst_pred_mode", 32'(sif.pred_mode), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_best_mode", 32'(best_mode), 0);
    check("rst_best_cost", 32'(best_cost), 32'hFFFF);
    check("rst_eval_cnt", 32'(eval_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Descending costs: last mode wins.
    for (int i = 0; i < NM; i++) cost_tab[i] = 100 - i;
    run_sweep("ramp", 70, 34, 66, 35);

    // Equal costs: planar kept on ties.
    for (int i = 0; i < NM; i++) cost_tab[i] = 50;
    run_sweep("tie", 70, 0, 50, 35);

    // Ack held off 3 cycles for mode 5: request visible 4 cycles, results unchanged.
    for (int i = 0; i < NM; i++) cost_tab[i] = 100 - i;
    stall_mode   = 5;
    stall_cycles = 3;
    stall_obs    = 0;
    run_sweep("stall", 73, 34, 66, 35);
    check("stall_req_cycles", stall_obs, 4);
    stall_mode = -1;

    // Abort in WAIT of mode 10, cost_valid asserted alongside it.
    for (int i = 0; i < NM; i++) cost_tab[i] = 3;
    abort_mode  = 10;
    abort_fired = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!abort_fired && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("abort_seen", 32'(abort_fired), 1);
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_pred_req", 32'(sif.pred_req), 0);
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_keep_mode", 32'(best_mode), 34);
    check("abort_keep_cost", 32'(best_cost), 66);
    check("abort_keep_eval", 32'(eval_cnt), 35);
    abort_mode = -1;

    // Stray cost_valid in ISSUE and a start mid-sweep are both ignored.
    for (int i = 0; i < NM; i++) cost_tab[i] = i + 10;
    stray_cv   = 1'b1;
    start_poke = 20;
    run_sweep("stray", 70, 0, 10, 35);
    stray_cv   = 1'b0;
    start_poke = -1;

    // Asynchronous reset mid-sweep.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_pred_req", 32'(sif.pred_req), 0);
    check("mrst_pred_mode", 32'(sif.pred_mode), 0);
    check("mrst_best_cost", 32'(best_cost), 32'hFFFF);
    check("mrst_best_mode", 32'(best_mode), 0);
    check("mrst_eval_cnt", 32'(eval_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_idle_after", 32'(busy), 0);

    // Single minimum in the middle of the range.
    for (int i = 0; i < NM; i++) cost_tab[i] = (i == 17) ? 3 : 500;
    run_sweep("mid", 70, 17, 3, 35);

`ifdef INTRA_EARLY_TERM_EN
    for (int i = 0; i < NM; i++) cost_tab[i] = (i == 1) ? 15 : 200;
    early_thr = 16'd20;
    run_sweep("early", 4, 1, 15, 2);
    early_thr = 16'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
